// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared Breakout constants and the frame-engine state type
// Contents:
//   screen limits, ball half-size, brick/paddle sizes, brick count,
//   clamp limits for the ball centre, frame-engine state enum
package breakout_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_HALF   = 2;

  localparam int BRICK_W     = 40;
  localparam int BRICK_H     = 20;
  localparam int PADDLE_W    = 80;
  localparam int PADDLE_H    = 10;

  localparam int BRICK_COUNT = 16;

  // Ball centre is kept so the whole ball stays on screen.
  localparam logic [10:0] BALL_X_MIN = 11'(BALL_HALF);
  localparam logic [10:0] BALL_X_MAX = 11'(SCREEN_W - 1 - BALL_HALF);
  localparam logic [10:0] BALL_Y_MIN = 11'(BALL_HALF);
  localparam logic [10:0] BALL_Y_MAX = 11'(SCREEN_H - 1 - BALL_HALF);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MOVE,
    SCAN,
    PADDLE,
    WALL,
    END,
    OVER
  } state_t;

endpackage

// File: rtl/brick_hit_test.sv
// rtl/brick_hit_test.sv - combinational ball-versus-brick overlap test
// Ports:
//   ball_x, ball_y : ball centre
//   index          : brick number 0..15 (col = index[2:0], row = index[3])
//   overlap        : high when the ball touches the brick rectangle
module brick_hit_test
  import breakout_pkg::*;
#(
  parameter int BLK_X0      = 160,
  parameter int BLK_Y0      = 60,
  parameter int BLK_PITCH_X = 40,
  parameter int BLK_PITCH_Y = 20
) (
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [3:0] index,
  output logic       overlap
);

  logic [10:0] bx;
  logic [10:0] by;
  logic [10:0] x;
  logic [10:0] y;

  // The ball half-size is added to the ball side or the brick side rather
  // than subtracted, so nothing can wrap below zero.
  always_comb begin
    bx = 11'(BLK_X0) + 11'(index[2:0]) * 11'(BLK_PITCH_X);
    by = 11'(BLK_Y0) + 11'(index[3]) * 11'(BLK_PITCH_Y);
    x  = {1'b0, ball_x};
    y  = {1'b0, ball_y};
    overlap = (x + 11'(BALL_HALF) > bx) &&
              (x < bx + 11'(BRICK_W + BALL_HALF)) &&
              (y + 11'(BALL_HALF) > by) &&
              (y < by + 11'(BRICK_H + BALL_HALF));
  end

endmodule

// File: rtl/breakout_frame_engine.sv
// rtl/breakout_frame_engine.sv - once-per-frame Breakout game-state update
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : active-low start / restart button
//   frame_tick        : one-cycle pulse per frame, during blanking
//   paddlex, paddley  : paddle left edge / top edge
//   ballx, bally      : ball centre
//   hit               : destroyed-brick flags, bit k = brick k
//   W, L              : sticky win / loss
//   busy              : high while a frame update runs
//   done              : one-cycle pulse when a frame update completes
module breakout_frame_engine
  import breakout_pkg::*;
#(
  parameter int SPEED       = 2,
  parameter int BALL_X0     = 320,
  parameter int BALL_Y0     = 400,
  parameter int DY0         = 0,
  parameter int BLK_X0      = 160,
  parameter int BLK_Y0      = 60,
  parameter int BLK_PITCH_X = 40,
  parameter int BLK_PITCH_Y = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [9:0]             paddlex,
  input  logic [9:0]             paddley,
  output logic [9:0]             ballx,
  output logic [9:0]             bally,
  output logic [BRICK_COUNT-1:0] hit,
  output logic                   W,
  output logic                   L,
  output logic                   busy,
  output logic                   done
);

  localparam logic DY_INIT = (DY0 != 0);

  state_t      state;
  logic        dx;        // 1 = right
  logic        dy;        // 1 = down
  logic [3:0]  scan_idx;
  logic        found;     // a brick was already taken this frame

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] x_next;
  logic [10:0] y_next;
  logic [10:0] px;
  logic [10:0] py;
  logic        brick_overlap;
  logic        candidate;
  logic        paddle_contact;
  logic        win_now;

  brick_hit_test #(
    .BLK_X0      (BLK_X0),
    .BLK_Y0      (BLK_Y0),
    .BLK_PITCH_X (BLK_PITCH_X),
    .BLK_PITCH_Y (BLK_PITCH_Y)
  ) u_brick_hit_test (
    .ball_x  (ballx),
    .ball_y  (bally),
    .index   (scan_idx),
    .overlap (brick_overlap)
  );

  // Next ball position with clamping; the left/up step checks against the
  // limit before subtracting so the 11-bit value never wraps.
  always_comb begin
    x_ext = {1'b0, ballx};
    y_ext = {1'b0, bally};
    px    = {1'b0, paddlex};
    py    = {1'b0, paddley};

    if (dx) begin
      x_next = x_ext + 11'(SPEED);
      if (x_next > BALL_X_MAX) x_next = BALL_X_MAX;
    end else begin
      if (x_ext < BALL_X_MIN + 11'(SPEED)) x_next = BALL_X_MIN;
      else                                 x_next = x_ext - 11'(SPEED);
    end

    if (dy) begin
      y_next = y_ext + 11'(SPEED);
      if (y_next > BALL_Y_MAX) y_next = BALL_Y_MAX;
    end else begin
      if (y_ext < BALL_Y_MIN + 11'(SPEED)) y_next = BALL_Y_MIN;
      else                                 y_next = y_ext - 11'(SPEED);
    end

    candidate      = brick_overlap && !hit[scan_idx];
    paddle_contact = (y_ext + 11'(BALL_HALF) >= py) &&
                     (y_ext < py + 11'(PADDLE_H)) &&
                     (x_ext + 11'(BALL_HALF) > px) &&
                     (x_ext < px + 11'(PADDLE_W + BALL_HALF));
    win_now        = (&hit) && !L;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ballx    <= 10'(BALL_X0);
      bally    <= 10'(BALL_Y0);
      dx       <= 1'b1;
      dy       <= DY_INIT;
      hit      <= '0;
      W        <= 1'b0;
      L        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      scan_idx <= 4'd0;
      found    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!start) state <= WAIT;
        end

        WAIT: begin
          if (frame_tick) begin
            busy  <= 1'b1;
            state <= MOVE;
          end
        end

        MOVE: begin
          ballx    <= x_next[9:0];
          bally    <= y_next[9:0];
          scan_idx <= 4'd0;
          found    <= 1'b0;
          state    <= SCAN;
        end

        // Always walks all 16 bricks so the frame length is fixed.
        SCAN: begin
          if (candidate && !found) begin
            hit[scan_idx] <= 1'b1;
            dy            <= ~dy;
            found         <= 1'b1;
          end
          scan_idx <= scan_idx + 4'd1;
          if (scan_idx == 4'd15) state <= PADDLE;
        end

        PADDLE: begin
          if (dy && paddle_contact) dy <= 1'b0;
          state <= WALL;
        end

        WALL: begin
          if (x_ext <= BALL_X_MIN && !dx)     dx <= 1'b1;
          else if (x_ext >= BALL_X_MAX && dx) dx <= 1'b0;
          if (y_ext <= BALL_Y_MIN && !dy)     dy <= 1'b1;
          if (y_ext >= BALL_Y_MAX)            L  <= 1'b1;
          state <= END;
        end

        // L was settled in WALL, so a loss in this frame blocks the win.
        END: begin
          if (win_now) W <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= (W || L || win_now) ? OVER : WAIT;
        end

        OVER: begin
          if (!start) begin
            ballx <= 10'(BALL_X0);
            bally <= 10'(BALL_Y0);
            dx    <= 1'b1;
            dy    <= DY_INIT;
            hit   <= '0;
            W     <= 1'b0;
            L     <= 1'b0;
            state <= WAIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_frame_engine.sv
// tb/tb_breakout_frame_engine.sv - randomized self-checking bench for breakout_frame_engine
module tb_breakout_frame_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        frame_tick;
  logic [9:0]  paddlex;
  logic [9:0]  paddley;
  logic [9:0]  ballx;
  logic [9:0]  bally;
  logic [15:0] hit;
  logic        W;
  logic        L;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model of the game state
  int          m_x, m_y;
  bit          m_dx, m_dy, m_w, m_l;
  logic [15:0] m_hit;
  int          mode;  // 0 idle, 1 waiting for frames, 2 game over

  always #5 clk = ~clk;

  breakout_frame_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_tick (frame_tick),
    .paddlex    (paddlex),
    .paddley    (paddley),
    .ballx      (ballx),
    .bally      (bally),
    .hit        (hit),
    .W          (W),
    .L          (L),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 400; m_dx = 1; m_dy = 0;
    m_hit = 16'h0; m_w = 0; m_l = 0;
  endtask

  // One whole frame worked out from the game rules.
  task automatic model_frame(input int px, input int py);
    bit found;
    int bx, by;
    m_x = m_dx ? m_x + 2 : m_x - 2;
    m_y = m_dy ? m_y + 2 : m_y - 2;
    if (m_x > 637) m_x = 637;
    if (m_x < 2)   m_x = 2;
    if (m_y > 477) m_y = 477;
    if (m_y < 2)   m_y = 2;
    found = 0;
    for (int k = 0; k < 16; k++) begin
      bx = 160 + (k % 8) * 40;
      by = 60 + (k / 8) * 20;
      if (!found && !m_hit[k] && m_x + 2 > bx && m_x < bx + 42 &&
          m_y + 2 > by && m_y < by + 22) begin
        m_hit[k] = 1'b1;
        m_dy = !m_dy;
        found = 1;
      end
    end
    if (m_dy && m_y + 2 >= py && m_y < py + 10 && m_x + 2 > px && m_x < px + 82)
      m_dy = 0;
    if (m_x <= 2 && !m_dx)       m_dx = 1;
    else if (m_x >= 637 && m_dx) m_dx = 0;
    if (m_y <= 2 && !m_dy)       m_dy = 1;
    if (m_y >= 477)              m_l = 1;
    if (m_hit == 16'hFFFF && !m_l) m_w = 1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".ballx"}, 32'(ballx), 320);
    check_eq({tag, ".bally"}, 32'(bally), 400);
    check_eq({tag, ".hit"},   32'(hit), 0);
    check_eq({tag, ".W"},     32'(W), 0);
    check_eq({tag, ".L"},     32'(L), 0);
    check_eq({tag, ".busy"},  32'(busy), 0);
    check_eq({tag, ".done"},  32'(done), 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values(tag);
    model_reset();
    mode = 0;
  endtask

  task automatic pulse_start();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  // Entered at a negedge with the DUT waiting; returns at a negedge.
  task automatic run_frame(input int px, input int py);
    int abort_at, extra_at;
    int old_x, old_y;
    logic [15:0] old_hit;
    abort_at = ($urandom_range(0, 63) == 0) ? int'($urandom_range(2, 20)) : 0;
    extra_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 19)) : 0;
    old_x = m_x; old_y = m_y; old_hit = m_hit;
    paddlex = 10'(px);
    paddley = 10'(py);
    model_frame(px, py);
    frame_tick = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 22; c++) begin
      frame_tick = 1'b0;
      check_eq("frame.busy", 32'(busy), (c <= 20) ? 1 : 0);
      check_eq("frame.done", 32'(done), (c == 21) ? 1 : 0);
      check_eq("frame.ballx", 32'(ballx), (c == 1) ? old_x : m_x);
      check_eq("frame.bally", 32'(bally), (c == 1) ? old_y : m_y);
      if (c == 1) check_eq("frame.hit_old", 32'(hit), 32'(old_hit));
      if (c <= 19) begin
        check_eq("frame.W_old", 32'(W), 0);
        check_eq("frame.L_old", 32'(L), 0);
      end
      if (c >= 21) begin
        check_eq("frame.hit", 32'(hit), 32'(m_hit));
        check_eq("frame.W", 32'(W), 32'(m_w));
        check_eq("frame.L", 32'(L), 32'(m_l));
      end
      if (c == abort_at) begin
        pulse_reset("abort");
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("abort.no_done", 32'(done), 0);
          check_eq("abort.no_busy", 32'(busy), 0);
        end
        return;
      end
      if (c == extra_at) frame_tick = 1'b1;
      if (c < 22) @(negedge clk);
    end
    mode = (m_w || m_l) ? 2 : 1;
  endtask

  // A tick where the engine must not react: no busy, no done, frozen state.
  task automatic ignored_tick(input string tag);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 22; i++) begin
      check_eq({tag, ".busy"}, 32'(busy), 0);
      check_eq({tag, ".done"}, 32'(done), 0);
      @(negedge clk);
    end
    check_eq({tag, ".ballx"}, 32'(ballx), 32'(m_x));
    check_eq({tag, ".bally"}, 32'(bally), 32'(m_y));
    check_eq({tag, ".hit"},   32'(hit), 32'(m_hit));
    check_eq({tag, ".W"},     32'(W), 32'(m_w));
    check_eq({tag, ".L"},     32'(L), 32'(m_l));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py;
    rst = 1'b1; start = 1'b1; frame_tick = 1'b0; paddlex = '0; paddley = 10'd420;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("reset");
    model_reset();
    mode = 0;

    for (int it = 0; it < 1400; it++) begin
      case (mode)
        0: begin
          if ($urandom_range(0, 3) == 0) ignored_tick("idle_tick");
          pulse_start();
          check_eq("idle_start.busy", 32'(busy), 0);
          mode = 1;
        end
        2: begin
          if ($urandom_range(0, 1) == 0) ignored_tick("over_tick");
          pulse_start();
          model_reset();
          check_reset_values("restart");
          mode = 1;
        end
        default: begin
          if ($urandom_range(0, 149) == 0) begin
            pulse_reset("wait_reset");
          end else begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
              start = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
              @(negedge clk);
              start = 1'b1;
              check_eq("gap.busy", 32'(busy), 0);
              check_eq("gap.done", 32'(done), 0);
            end
            if ($urandom_range(0, 7) != 0) begin
              px = m_x - int'($urandom_range(1, 75));
              if (px < 0) px = 0;
              py = 420;
            end else begin
              px = int'($urandom_range(0, 559));
              py = int'($urandom_range(380, 450));
            end
            run_frame(px, py);
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
